clock_divider_ctrl: RTL

Programmable system-clock controller for the 8-bit CPU. Divides the fabric clock by a runtime divide value and produces a single-cycle CPU enable, `cpu_tick`, plus a visible square wave, `clk_out`, for LEDs/debug. Supports free-run, single-step from a debounced push-button, and a sticky halt driven by the CPU's HLT instruction. Sits at top level and feeds `cpu_tick` to every CPU register enable.

---
 rtl/clock_divider_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/clock_divider_ctrl.sv
// Programmable CPU clock controller: free-run divider, debounced
// single-step, sticky halt latch and a tick counter.
module clock_divider_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] limit,
  input  logic             mode,
  input  logic             step_btn,
  input  logic             halt,
  input  logic             resume,
  output logic             cpu_tick,
  output logic             clk_out,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DBC_W = $clog2(DB_CYCLES + 1);
  localparam logic [DBC_W-1:0] DB_LAST = DBC_W'(DB_CYCLES - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             mode_q, mode_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             db_prev_q, db_prev_d;
  logic [DBC_W-1:0] db_cnt_q, db_cnt_d;

  logic             mode_chg;
  logic [DIV_W-1:0] lim_m1;

  always_comb begin
    sync1_d   = step_btn;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_cnt_d  = '0;
    db_prev_d = db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    halted_d = halted_q;
    if (halt) begin
      halted_d = 1'b1;
    end else if (resume) begin
      halted_d = 1'b0;
    end
  end

  assign mode_chg = (mode != mode_q);
  assign lim_m1   = limit - DIV_W'(1);

  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    mode_d    = mode;
    cycle_d   = cycle_q + CNT_W'(tick_q);
    // halt on this edge also kills a tick that would fire now
    if (halted_q || halt || mode_chg) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (!mode) begin
      if (limit == '0) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end else if (cnt_q >= lim_m1) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      if (db_q && !db_prev_q) begin
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
      end else if (!db_q && db_prev_q) begin
        clk_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      halted_q  <= 1'b0;
      cycle_q   <= '0;
      mode_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      halted_q  <= halted_d;
      cycle_q   <= cycle_d;
      mode_q    <= mode_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign cpu_tick  = tick_q;
  assign clk_out   = clk_out_q;
  assign halted    = halted_q;
  assign cycle_cnt = cycle_q;

endmodule
